// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared pipeline constants and helpers for the IF/ID queue
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef PC_INIT_ADDR
`define PC_INIT_ADDR 32'h0000_0000
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

package if_id_queue_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_DEPTH  = 4;

    // Count must hold 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch-side and decode-side signals of the IF/ID queue
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    import if_id_queue_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_stall;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output if_valid, if_pc, if_inst, id_stall,
        input  if_ready, id_pc, id_inst, id_valid, q_count
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_stall,
        output if_ready, id_pc, id_inst, id_valid, q_count
    );
endinterface

// File: rtl/if_id_queue_fifo.sv
// rtl/if_id_queue_fifo.sv - if_id_fifo: circular instruction buffer with pointers and count
module if_id_fifo
    import if_id_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         full,
    output logic                         empty
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID instruction queue with ID output register; IF_ID_QUEUE_BYPASS_EN enables empty-queue bypass
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                INST_W    = DEF_INST_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] BUBBLE_PC = `PC_INIT_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    if_id_queue_if.slave bus
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int W     = ADDR_W + INST_W;

    logic [W-1:0]     head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             advance;
    logic             take_in;
    logic             push;
    logic             pop;

    logic [ADDR_W-1:0] id_pc_q;
    logic [INST_W-1:0] id_inst_q;
    logic              id_valid_q;

    assign advance = !bus.id_stall && !flush;
    assign pop     = advance && !empty;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign take_in = advance && empty && bus.if_valid;
`else
    assign take_in = 1'b0;
`endif

    // A bypassed beat goes straight to ID and must not also be queued.
    assign push = bus.if_valid && !full && !flush && !take_in;

    if_id_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.if_pc, bus.if_inst}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else if (flush) begin
            id_pc_q    <= BUBBLE_PC;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else if (advance) begin
            if (!empty) begin
                {id_pc_q, id_inst_q} <= head;
                id_valid_q           <= 1'b1;
            end else if (take_in) begin
                id_pc_q    <= bus.if_pc;
                id_inst_q  <= bus.if_inst;
                id_valid_q <= 1'b1;
            end else begin
                id_pc_q    <= BUBBLE_PC;
                id_inst_q  <= '0;
                id_valid_q <= 1'b0;
            end
        end
    end

    // if_ready looks only at the registered count so a stall cannot reach fetch PC logic.
    assign bus.if_ready = !full;
    assign bus.q_count  = count;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;
    localparam int          AW  = 32;
    localparam int          IW  = 32;
    localparam int          D   = 4;
    localparam logic [31:0] BPC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   failures = 0;

    if_id_queue_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D)) bus ();

    if_id_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .BUBBLE_PC(BPC)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst_of(pc);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; bus.id_stall = 1'b0;
        drive(1'b0, 32'h0);
        #3;
        checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=%h", bus.id_pc, 32'h0); end
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
        checks++; if (bus.q_count !== 3'd0) begin failures++; $display("FAIL reset_q_count got=%0d exp=0", bus.q_count); end
        checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", bus.if_ready); end
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.id_pc !== BPC) begin failures++; $display("FAIL idle_bubble_pc got=%h exp=%h", bus.id_pc, BPC); end
        checks++; if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0) begin failures++; $display("FAIL idle_bubble got valid=%b inst=%h exp valid=0 inst=0", bus.id_valid, bus.id_inst); end
        checks++; if (bus.q_count !== 3'd0) begin failures++; $display("FAIL idle_q_count got=%0d exp=0", bus.q_count); end
    endtask

    task automatic test_stream();
        logic [31:0] in_pc [5];
        logic        in_v  [5];
        logic [31:0] ep    [5];
        logic        ev    [5];
        logic [2:0]  eq    [5];
        in_pc = '{32'h100, 32'h104, 32'h108, 32'h0, 32'h0};
        in_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef IF_ID_QUEUE_BYPASS_EN
        ep = '{32'h100, 32'h104, 32'h108, BPC, BPC};
        ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        eq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        ep = '{BPC, 32'h100, 32'h104, 32'h108, BPC};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        eq = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            drive(in_v[i], in_pc[i]);
            step();
            checks++;
            if (bus.id_valid !== ev[i] || bus.id_pc !== ep[i] || bus.q_count !== eq[i]) begin
                failures++;
                $display("FAIL stream[%0d] got v=%b pc=%h q=%0d exp v=%b pc=%h q=%0d", i, bus.id_valid, bus.id_pc, bus.q_count, ev[i], ep[i], eq[i]);
            end
        end
    endtask

    task automatic test_stall_fill();
        logic [31:0] expq [5];
        logic        pending;
        logic        accepted;
        int          n;
        logic        extra;
        expq = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210};
        bus.id_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, expq[k]);
            checks++;
            if (bus.if_ready !== (k < 4)) begin failures++; $display("FAIL stall_if_ready[%0d] got=%b exp=%b", k, bus.if_ready, (k < 4)); end
            step();
            checks++;
            if (bus.q_count !== 3'((k < 4) ? k + 1 : 4)) begin failures++; $display("FAIL stall_q_count[%0d] got=%0d exp=%0d", k, bus.q_count, (k < 4) ? k + 1 : 4); end
        end
        checks++; if (bus.id_valid !== 1'b0 || bus.id_pc !== BPC) begin failures++; $display("FAIL stall_held_output got v=%b pc=%h exp v=0 pc=%h", bus.id_valid, bus.id_pc, BPC); end
        bus.id_stall = 1'b0;
        pending = 1'b1;
        n = 0;
        extra = 1'b0;
        for (int t = 0; t < 10; t++) begin
            bus.if_valid = pending;
            accepted = pending && bus.if_ready;
            step();
            if (accepted) pending = 1'b0;
            if (t == 0) begin
                checks++; if (bus.q_count !== 3'd3) begin failures++; $display("FAIL release_q_count got=%0d exp=3", bus.q_count); end
            end
            if (bus.id_valid === 1'b1) begin
                if (n < 5) begin
                    checks++;
                    if (bus.id_pc !== expq[n] || bus.id_inst !== inst_of(expq[n])) begin
                        failures++;
                        $display("FAIL drain_order[%0d] got pc=%h inst=%h exp pc=%h inst=%h", n, bus.id_pc, bus.id_inst, expq[n], inst_of(expq[n]));
                    end
                end else begin
                    extra = 1'b1;
                end
                n++;
            end
        end
        checks++; if (n != 5 || extra) begin failures++; $display("FAIL drain_count got=%0d exp=5", n); end
        drive(1'b0, 32'h0);
    endtask

    task automatic test_bubbles();
        logic [31:0] in_pc [6];
        logic        in_v  [6];
        logic [31:0] ep    [6];
        logic        ev    [6];
        in_pc = '{32'h300, 32'h0, 32'h0, 32'h304, 32'h0, 32'h0};
        in_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef IF_ID_QUEUE_BYPASS_EN
        ep = '{32'h300, BPC, BPC, 32'h304, BPC, BPC};
        ev = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        ep = '{BPC, 32'h300, BPC, BPC, 32'h304, BPC};
        ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            drive(in_v[i], in_pc[i]);
            step();
            checks++;
            if (bus.id_valid !== ev[i] || bus.id_pc !== ep[i] || bus.id_inst !== (ev[i] ? inst_of(ep[i]) : 32'h0)) begin
                failures++;
                $display("FAIL bubble_empty[%0d] got v=%b pc=%h inst=%h exp v=%b pc=%h", i, bus.id_valid, bus.id_pc, bus.id_inst, ev[i], ep[i]);
            end
        end
        // Queue already holds entries: the fetch gap must not show up at ID.
        bus.id_stall = 1'b1;
        drive(1'b1, 32'h400); step();
        drive(1'b1, 32'h404); step();
        bus.id_stall = 1'b0;
        drive(1'b0, 32'h0);
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h400) begin failures++; $display("FAIL queued_gap0 got v=%b pc=%h exp v=1 pc=%h", bus.id_valid, bus.id_pc, 32'h400); end
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h404) begin failures++; $display("FAIL queued_gap1 got v=%b pc=%h exp v=1 pc=%h", bus.id_valid, bus.id_pc, 32'h404); end
        step();
        checks++; if (bus.id_valid !== 1'b0 || bus.id_pc !== BPC) begin failures++; $display("FAIL queued_gap2 got v=%b pc=%h exp v=0 pc=%h", bus.id_valid, bus.id_pc, BPC); end
    endtask

    task automatic test_flush();
        logic seen;
        drive(1'b1, 32'h4F0);
        step();
`ifndef IF_ID_QUEUE_BYPASS_EN
        drive(1'b0, 32'h0);
        step();
`endif
        bus.id_stall = 1'b1;
        drive(1'b1, 32'h500); step();
        drive(1'b1, 32'h504); step();
        drive(1'b1, 32'h508); step();
        checks++; if (bus.q_count !== 3'd3) begin failures++; $display("FAIL preflush_q_count got=%0d exp=3", bus.q_count); end
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h4F0) begin failures++; $display("FAIL preflush_hold got v=%b pc=%h exp v=1 pc=%h", bus.id_valid, bus.id_pc, 32'h4F0); end
        flush = 1'b1;
        drive(1'b1, 32'h50C);
        step();
        flush = 1'b0;
        checks++; if (bus.q_count !== 3'd0) begin failures++; $display("FAIL flush_q_count got=%0d exp=0", bus.q_count); end
        checks++; if (bus.id_valid !== 1'b0 || bus.id_pc !== BPC || bus.id_inst !== 32'h0) begin failures++; $display("FAIL flush_output got v=%b pc=%h inst=%h exp v=0 pc=%h inst=0", bus.id_valid, bus.id_pc, bus.id_inst, BPC); end
        checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL flush_if_ready got=%b exp=1", bus.if_ready); end
        bus.id_stall = 1'b0;
        drive(1'b0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.id_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_leak got=1 exp=0"); end
    endtask

    task automatic test_async_reset();
        bus.id_stall = 1'b1;
        drive(1'b1, 32'h600); step();
        drive(1'b1, 32'h604); step();
        drive(1'b0, 32'h0);
        checks++; if (bus.q_count !== 3'd2) begin failures++; $display("FAIL prerst_q_count got=%0d exp=2", bus.q_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.q_count !== 3'd0) begin failures++; $display("FAIL async_q_count got=%0d exp=0", bus.q_count); end
        checks++; if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 || bus.id_valid !== 1'b0) begin failures++; $display("FAIL async_outputs got v=%b pc=%h inst=%h exp all zero", bus.id_valid, bus.id_pc, bus.id_inst); end
        #1;
        rst = 1'b0;
        bus.id_stall = 1'b0;
        drive(1'b1, 32'h700);
        step();
        drive(1'b0, 32'h0);
`ifdef IF_ID_QUEUE_BYPASS_EN
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h700) begin failures++; $display("FAIL latency_edge1 got v=%b pc=%h exp v=1 pc=%h", bus.id_valid, bus.id_pc, 32'h700); end
        step();
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL latency_edge2 got v=%b exp v=0", bus.id_valid); end
`else
        checks++; if (bus.id_valid !== 1'b0 || bus.q_count !== 3'd1) begin failures++; $display("FAIL latency_edge1 got v=%b q=%0d exp v=0 q=1", bus.id_valid, bus.q_count); end
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h700) begin failures++; $display("FAIL latency_edge2 got v=%b pc=%h exp v=1 pc=%h", bus.id_valid, bus.id_pc, 32'h700); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_bubbles();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
